// File: rtl/mac_pe_param.sv
// mac_pe_param -- weight-stationary multiply-accumulate processing element
// for a systolic array.
//
// Weights shift down a column through inp_north/outp_south, one PE per
// wload cycle. Activations move east and partial sums accumulate west to
// east: result = inp_west + W * inp_matrix, one cycle of latency.
//
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   en                clock enable, 0 = every register holds
//   wload             weight-load strobe (wins over vld_in)
//   inp_north         weight chain in        outp_south  weight chain out
//   wload_out         wload forwarded south
//   inp_matrix        activation in          act_east    activation out
//   inp_west          partial sum in         result      partial sum out
//   vld_in            activation valid       vld_out     result valid
//   ovf               sticky overflow (cleared by wload)
//   mac_cnt           MACs since last load, saturating
//   st                FSM state: 0 EMPTY, 1 LOADED, 2 RUN
module mac_pe_param #(
    parameter int DW     = 8,
    parameter int AW     = 20,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          wload,
    input  logic [DW-1:0] inp_north,
    output logic [DW-1:0] outp_south,
    output logic          wload_out,
    input  logic [DW-1:0] inp_matrix,
    output logic [DW-1:0] act_east,
    input  logic [AW-1:0] inp_west,
    input  logic          vld_in,
    output logic [AW-1:0] result,
    output logic          vld_out,
    output logic          ovf,
    output logic [15:0]   mac_cnt,
    output logic [1:0]    st
);

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] LOADED = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] w_q, south_q, act_q;
    logic [AW-1:0] res_q, res_d;
    logic          vld_q, wlo_q, ovf_q;
    logic [15:0]   cnt_q;

    logic load, mac_go;
    assign load   = en & wload;
    assign mac_go = en & vld_in & ~wload;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = LOADED;
        end else if (en) begin
            case (state_q)
                LOADED:  if (vld_in)  state_d = RUN;
                RUN:     if (!vld_in) state_d = LOADED;
                default: state_d = state_q;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Until a weight has been loaded the PE behaves as a wire for the
    // partial sum, so the weight reads as zero and MACs are not counted.
    logic [DW-1:0] w_eff;
    logic          cnt_inc;
    always_comb begin
        w_eff   = (state_q == EMPTY) ? '0 : w_q;
        cnt_inc = mac_go && (state_q != EMPTY) && (cnt_q != 16'hFFFF);
    end

    // ---------------- datapath ----------------
    // The sum is formed one bit wider than AW so overflow can be read off
    // the extra bit (unsigned carry, or sign disagreement when signed).
    logic [2*DW-1:0]        prod_u, prod;
    logic signed [2*DW-1:0] prod_s;
    logic [AW:0]            prod_x, west_x, sum;
    logic                   ovf_det;
    logic [AW-1:0]          clamp;

    always_comb begin
        prod_u = {{DW{1'b0}}, w_eff} * {{DW{1'b0}}, inp_matrix};
        prod_s = $signed({{DW{w_eff[DW-1]}}, w_eff}) *
                 $signed({{DW{inp_matrix[DW-1]}}, inp_matrix});
        prod   = (SIGNED != 0) ? $unsigned(prod_s) : prod_u;
        prod_x = {{(AW+1-2*DW){(SIGNED != 0) & prod[2*DW-1]}}, prod};
        west_x = {(SIGNED != 0) & inp_west[AW-1], inp_west};
        sum    = west_x + prod_x;
        if (SIGNED != 0) begin
            ovf_det = sum[AW] ^ sum[AW-1];
            clamp   = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            ovf_det = sum[AW];
            clamp   = '1;
        end
        res_d = (ovf_det && (SAT != 0)) ? clamp : sum[AW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q     <= '0;
            south_q <= '0;
            act_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            wlo_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            w_q     <= inp_north;
            south_q <= w_q;
            wlo_q   <= 1'b1;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else if (en) begin
            wlo_q <= 1'b0;
            if (mac_go) begin
                res_q <= res_d;
                vld_q <= 1'b1;
                act_q <= inp_matrix;
                if (ovf_det) ovf_q <= 1'b1;
                if (cnt_inc) cnt_q <= cnt_q + 16'd1;
            end else begin
                vld_q <= 1'b0;
            end
        end
    end

    assign outp_south = south_q;
    assign wload_out  = wlo_q;
    assign act_east   = act_q;
    assign result     = res_q;
    assign vld_out    = vld_q;
    assign ovf        = ovf_q;
    assign mac_cnt    = cnt_q;
    assign st         = state_q;

endmodule

// File: tb/tb_mac_pe_param.sv
// Bench for mac_pe_param: three parameterisations driven by one shared
// stimulus stream (unsigned/SAT AW=20, unsigned/SAT AW=17, signed/wrap
// AW=20), each checked every cycle against a behavioural model, plus
// literal expectations on the directed scenarios.
module tb_mac_pe_param;

    logic        clk = 1'b0;
    logic        rst, en, wload, vld_in;
    logic [7:0]  inp_north, inp_matrix;
    logic [19:0] inp_west;

    logic [7:0]  south0, south1, south2, act0, act1, act2;
    logic        wlo0, wlo1, wlo2, vld0, vld1, vld2, ovf0, ovf1, ovf2;
    logic [19:0] res0, res2;
    logic [16:0] res1;
    logic [15:0] cnt0, cnt1, cnt2;
    logic [1:0]  st0, st1, st2;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    always #5 clk = ~clk;

    mac_pe_param #(.DW(8), .AW(20), .SIGNED(0), .SAT(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .wload(wload), .inp_north(inp_north),
        .outp_south(south0), .wload_out(wlo0), .inp_matrix(inp_matrix),
        .act_east(act0), .inp_west(inp_west), .vld_in(vld_in), .result(res0),
        .vld_out(vld0), .ovf(ovf0), .mac_cnt(cnt0), .st(st0));

    mac_pe_param #(.DW(8), .AW(17), .SIGNED(0), .SAT(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .wload(wload), .inp_north(inp_north),
        .outp_south(south1), .wload_out(wlo1), .inp_matrix(inp_matrix),
        .act_east(act1), .inp_west(inp_west[16:0]), .vld_in(vld_in), .result(res1),
        .vld_out(vld1), .ovf(ovf1), .mac_cnt(cnt1), .st(st1));

    mac_pe_param #(.DW(8), .AW(20), .SIGNED(1), .SAT(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .wload(wload), .inp_north(inp_north),
        .outp_south(south2), .wload_out(wlo2), .inp_matrix(inp_matrix),
        .act_east(act2), .inp_west(inp_west), .vld_in(vld_in), .result(res2),
        .vld_out(vld2), .ovf(ovf2), .mac_cnt(cnt2), .st(st2));

    // ---------------- behavioural model ----------------
    typedef struct {
        longint w, south, act, res;
        bit     wlo, vld, ovf, loaded, run;
        int     cnt;
    } mdl_t;

    mdl_t m[3];
    int   p_aw[3]  = '{20, 17, 20};
    bit   p_sg[3]  = '{0, 0, 1};
    bit   p_sat[3] = '{1, 1, 0};

    function automatic longint to_val(longint v, int n, bit sg);
        if (sg && v[n-1]) return v - (longint'(1) << n);
        return v;
    endfunction

    function automatic int st_of(int i);
        if (!m[i].loaded) return 0;
        return m[i].run ? 2 : 1;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 3; i++) begin
            m[i].w = 0; m[i].south = 0; m[i].act = 0; m[i].res = 0;
            m[i].wlo = 0; m[i].vld = 0; m[i].ovf = 0; m[i].loaded = 0;
            m[i].run = 0; m[i].cnt = 0;
        end
    endtask

    task automatic mdl_step(int i);
        longint mask, wv, av, wst, sum, lo, hi;
        int aw;
        aw   = p_aw[i];
        mask = (longint'(1) << aw) - 1;
        if (!en) return;
        if (wload) begin
            m[i].south = m[i].w;
            m[i].w = longint'(inp_north);
            m[i].wlo = 1; m[i].ovf = 0; m[i].cnt = 0; m[i].vld = 0;
            m[i].loaded = 1; m[i].run = 0;
        end else begin
            m[i].wlo = 0;
            if (vld_in) begin
                wv  = m[i].loaded ? to_val(m[i].w, 8, p_sg[i]) : 0;
                av  = to_val(longint'(inp_matrix), 8, p_sg[i]);
                wst = to_val(longint'(inp_west) & mask, aw, p_sg[i]);
                sum = wst + wv * av;
                lo  = p_sg[i] ? -(longint'(1) << (aw - 1)) : 0;
                hi  = p_sg[i] ? (longint'(1) << (aw - 1)) - 1 : mask;
                if (sum > hi || sum < lo) begin
                    m[i].ovf = 1;
                    if (p_sat[i]) sum = (sum > hi) ? hi : lo;
                end
                m[i].res = sum & mask;
                m[i].vld = 1;
                m[i].act = longint'(inp_matrix);
                if (m[i].loaded && m[i].cnt < 65535) m[i].cnt++;
                m[i].run = m[i].loaded;
            end else begin
                m[i].vld = 0;
                m[i].run = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) mdl_clear();
        else for (int i = 0; i < 3; i++) mdl_step(i);
    end

    // ---------------- checking ----------------
    task automatic chk(string name, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_inst(int i, longint res, bit vld, bit ovf, int cnt, int st,
                            longint south, longint act, bit wlo);
        chk($sformatf("u%0d.result", i), res, m[i].res);
        chk($sformatf("u%0d.vld_out", i), longint'(vld), longint'(m[i].vld));
        chk($sformatf("u%0d.ovf", i), longint'(ovf), longint'(m[i].ovf));
        chk($sformatf("u%0d.mac_cnt", i), longint'(cnt), longint'(m[i].cnt));
        chk($sformatf("u%0d.st", i), longint'(st), longint'(st_of(i)));
        chk($sformatf("u%0d.outp_south", i), south, m[i].south);
        chk($sformatf("u%0d.act_east", i), act, m[i].act);
        chk($sformatf("u%0d.wload_out", i), longint'(wlo), longint'(m[i].wlo));
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            cmp_inst(0, longint'(res0), vld0, ovf0, int'(cnt0), int'(st0),
                     longint'(south0), longint'(act0), wlo0);
            cmp_inst(1, longint'(res1), vld1, ovf1, int'(cnt1), int'(st1),
                     longint'(south1), longint'(act1), wlo1);
            cmp_inst(2, longint'(res2), vld2, ovf2, int'(cnt2), int'(st2),
                     longint'(south2), longint'(act2), wlo2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit e, bit wl, bit v, logic [7:0] n, logic [7:0] a, logic [19:0] w);
        en = e; wload = wl; vld_in = v; inp_north = n; inp_matrix = a; inp_west = w;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 8'd0, 8'd0, 20'd0);
        tick(); tick();
        chk("reset.result", longint'(res0), 0);
        chk("reset.st", longint'(st0), 0);
        chk("reset.vld_out", longint'(vld0), 0);
        rst = 1'b0;
        cmp_on = 1;

        // defaults: load 3, then 10 + 3*5
        drive(1, 1, 0, 8'd3, 8'd0, 20'd0);   tick();
        drive(1, 0, 1, 8'd0, 8'd5, 20'd10);  tick();
        chk("dflt.result", longint'(res0), 25);
        chk("dflt.vld_out", longint'(vld0), 1);
        chk("dflt.mac_cnt", longint'(cnt0), 1);
        chk("dflt.st", longint'(st0), 2);

        // chain load 7 then 9
        drive(1, 1, 0, 8'd7, 8'd0, 20'd0);   tick();
        chk("chain1.outp_south", longint'(south0), 3);
        chk("chain1.wload_out", longint'(wlo0), 1);
        drive(1, 1, 0, 8'd9, 8'd0, 20'd0);   tick();
        chk("chain2.outp_south", longint'(south0), 7);
        chk("chain2.wload_out", longint'(wlo0), 1);
        drive(1, 0, 1, 8'd0, 8'd1, 20'd0);   tick();
        chk("chain.w9", longint'(res0), 9);
        chk("chain.wload_out_low", longint'(wlo0), 0);

        // saturation on the AW=17 instance
        drive(1, 1, 0, 8'd255, 8'd0, 20'd0);        tick();
        drive(1, 0, 1, 8'd0, 8'd255, 20'd130972);   tick();
        chk("sat.result", longint'(res1), 131071);
        chk("sat.ovf", longint'(ovf1), 1);
        chk("sat.wide_result", longint'(res0), 195997);
        drive(1, 1, 0, 8'hFE, 8'd0, 20'd0);         tick();
        chk("sat.ovf_clear", longint'(ovf1), 0);

        // signed instance: -2*3+1, then wrap on positive overflow
        drive(1, 0, 1, 8'd0, 8'd3, 20'd1);          tick();
        chk("sgn.result", longint'(res2), 20'hFFFFB);
        drive(1, 0, 1, 8'd0, 8'hFF, 20'h7FFFF);     tick();
        chk("sgn.wrap", longint'(res2), 20'h80001);
        chk("sgn.ovf", longint'(ovf2), 1);
        chk("sgn.u0_result", longint'(res0), 589057);

        // stall holds everything, including vld_out
        drive(0, 0, 1, 8'd0, 8'd7, 20'd100);        tick();
        chk("stall.result", longint'(res0), 589057);
        chk("stall.mac_cnt", longint'(cnt0), 2);
        chk("stall.vld_out", longint'(vld0), 1);

        // collision: wload wins
        drive(1, 1, 1, 8'd5, 8'd2, 20'd0);          tick();
        chk("coll.vld_out", longint'(vld0), 0);
        chk("coll.result", longint'(res0), 589057);
        chk("coll.mac_cnt", longint'(cnt0), 0);
        drive(1, 0, 1, 8'd0, 8'd2, 20'd0);          tick();
        chk("coll.w5", longint'(res0), 10);

        // reset mid-RUN, then pass-through in EMPTY
        drive(1, 0, 1, 8'd0, 8'd4, 20'd3);
        rst = 1'b1;
        #1;
        chk("rstrun.result", longint'(res0), 0);
        chk("rstrun.vld_out", longint'(vld0), 0);
        chk("rstrun.st", longint'(st0), 0);
        chk("rstrun.mac_cnt", longint'(cnt0), 0);
        chk("rstrun.act_east", longint'(act0), 0);
        tick();
        rst = 1'b0;
        drive(1, 0, 1, 8'd0, 8'd5, 20'd42);
        #1;
        chk("rstrel.vld_out", longint'(vld0), 0);
        tick();
        chk("empty.result", longint'(res0), 42);
        chk("empty.mac_cnt", longint'(cnt0), 0);
        chk("empty.st", longint'(st0), 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [19:0] w;
            case ($urandom_range(0, 3))
                0:       w = 20'hFFFFF - 20'($urandom_range(0, 70000));
                1:       w = 20'h7FFFF - 20'($urandom_range(0, 70000));
                2:       w = 20'($urandom_range(0, 300));
                default: w = 20'($urandom);
            endcase
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom), w);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_pe_param.md
MAC_PE_PARAM -- requirements
Module: mac_pe_param

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DW, 8: weight/activation width.
- AW, 20: partial-sum/result width; AW >= 2*DW+1.
- SIGNED, 0: 1 = two's-complement operands and sums; 0 = unsigned.
- SAT, 1: 1 = clamp on overflow; 0 = wrap modulo 2^AW.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- en, in, 1: clock enable; 0 = full stall, all registers hold.
- wload, in, 1: weight-load strobe.
- inp_north, in, DW: weight chain in.
- outp_south, out, DW: weight chain out.
- wload_out, out, 1: wload forwarded south.
- inp_matrix, in, DW: activation.
- act_east, out, DW: activation forwarded east.
- inp_west, in, AW: partial sum in.
- vld_in, in, 1: activation/partial-sum valid.
- result, out, AW: partial sum out.
- vld_out, out, 1: result valid.
- ovf, out, 1: sticky overflow.
- mac_cnt, out, 16: MACs since last load.
- st, out, 2: FSM state.

REQ-003 One clock: clk; reset is asynchronous and active-high, port rst; all registers SHALL clear immediately on rst=1, independent of clk.

Function
REQ-004 All outputs SHALL be registered; nothing is driven combinationally from inputs.

REQ-005 FSM states SHALL be EMPTY=0, LOADED=1, RUN=2.
- Any state, wload&en -> LOADED.
- LOADED, vld_in&en&!wload -> RUN.
- RUN, !vld_in&en -> LOADED.
- Otherwise the state holds.

REQ-006 On a cycle with wload&en, the block SHALL:
- capture W <= inp_north;
- shift outp_south <= W (previous W);
- set wload_out <= 1;
- clear ovf and mac_cnt;
- drive vld_out <= 0 and hold result.

A column of N PEs therefore loads in N consecutive wload cycles.

REQ-007 On a cycle with en&!wload, wload_out SHALL be 0 and outp_south SHALL hold.

REQ-008 On a cycle with vld_in&en&!wload, the block SHALL compute with 1-cycle latency:
- result <= inp_west + W*inp_matrix, with a 2*DW-bit product extended to AW bits (sign- or zero-extended per SIGNED);
- set vld_out <= 1;
- forward act_east <= inp_matrix.

REQ-009 In state EMPTY, W SHALL read as 0, so result = inp_west (pass-through) and mac_cnt does not increment.

REQ-010 Overflow handling SHALL follow SAT.
- SAT=1: on overflow, result clamps to the AW-bit maximum/minimum (unsigned: 2^AW-1 or 0; signed: 2^(AW-1)-1 or -2^(AW-1)).
- Either SAT setting: ovf <= 1 and stays set until wload or rst.

REQ-011 On a cycle with en and !vld_in, vld_out SHALL be 0 and result and act_east SHALL hold.

REQ-012 mac_cnt SHALL increment by 1 per MAC in LOADED/RUN and saturate at 16'hFFFF.

REQ-013 On a cycle with en=0, every register SHALL hold, including vld_out (a stall extends the valid pulse).

REQ-014 When wload and vld_in are both 1, wload SHALL win: no MAC is performed and vld_out=0.

Reset
REQ-015 When rst=1, the block SHALL force:
- result=0, outp_south=0, act_east=0, W=0;
- vld_out=0, wload_out=0, ovf=0, mac_cnt=0;
- st=EMPTY.

REQ-016 A reset asserted mid-RUN SHALL discard the in-flight MAC; the first cycle after release SHALL show vld_out=0.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Defaults: wload with inp_north=3; next cycle vld_in, inp_matrix=5, inp_west=10 -> result=25, vld_out=1, mac_cnt=1, st=RUN.
- Chain load: wload for 2 cycles with inp_north=7 then 9 -> W=9, outp_south=7, wload_out=1 on both cycles.
- Saturation, SAT=1, DW=8, AW=17, unsigned: W=255, inp_matrix=255, inp_west=2^17-100 -> result=131071, ovf=1; a following wload clears ovf.
- Signed mode, SIGNED=1: W=-2 (8'hFE), inp_matrix=3, inp_west=1 -> result=-5; with SAT=0, inp_west at the AW-bit maximum -> result wraps and ovf=1.
- Stall and collision: vld_in with en=0 -> no result change and mac_cnt constant; wload and vld_in together -> W updated, vld_out=0.
- Reset mid-RUN, plus an EMPTY check: assert rst during vld_in -> all outputs 0 and st=EMPTY; then vld_in with inp_west=42 -> result=42, mac_cnt=0.
